// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - request/result bundle between a requester and div_unit
import div_pkg::*;

interface div_if #(parameter int WIDTH = DIV_WIDTH) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  lo, hi, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output lo, hi, busy, done, div_zero
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Shift in the next dividend bit; a borrow out of the trial subtraction
    // (top bit set) means the divisor did not fit and the remainder is restored.
    // The partial remainder stays below the divisor, so WIDTH+1 bits suffice.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_dvs};
        o_q     = ~w_diff[WIDTH];
        o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider, WIDTH+2 cycle latency; DIV_SIGNED_EN selects two's-complement operands
import div_pkg::*;

module div_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);

    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH - 1);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

`ifdef DIV_SIGNED_EN
    assign w_dvd_neg = bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.divisor[WIDTH-1];
`else
    assign w_dvd_neg = 1'b0;
    assign w_dvs_neg = 1'b0;
`endif

    // Most-negative value maps to itself, which read as unsigned is its true magnitude.
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

    // r_quo starts as the dividend magnitude and is shifted out MSB first
    // while quotient bits are shifted in at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_dvs (r_dvs),
        .i_bit (r_quo[WIDTH-1]),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                        if (bus.divisor == '0) begin
                            // hi/lo keep their previous result
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_count <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    if (r_count == LAST_STEP) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                FIX: begin
                    // sign flags are always clear in the unsigned build
                    r_lo    <= r_neg_q ? -r_quo : r_quo;
                    r_hi    <= r_neg_r ? -r_rem : r_rem;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.lo       = r_lo;
    assign bus.hi       = r_hi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit; expectations follow DIV_SIGNED_EN
module tb_div_unit;

    localparam int W = 32;

`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0] NEG_LO = 32'hFFFF_FFFD, NEG_HI = 32'hFFFF_FFFF;
    localparam logic [W-1:0] OVF_LO = 32'h8000_0000, OVF_HI = 32'h0000_0000;
    localparam logic [W-1:0] MIX_LO = 32'hFFFF_FFFD, MIX_HI = 32'h0000_0001;
`else
    localparam logic [W-1:0] NEG_LO = 32'h7FFF_FFFC, NEG_HI = 32'h0000_0001;
    localparam logic [W-1:0] OVF_LO = 32'h0000_0000, OVF_HI = 32'h8000_0000;
    localparam logic [W-1:0] MIX_LO = 32'h0000_0000, MIX_HI = 32'h0000_0007;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   seen_done;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           t0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("lo", bus.lo, mon_e.lo);
                check("hi", bus.hi, mon_e.hi);
                check("div_zero", W'(bus.div_zero), W'(mon_e.dz));
                check("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic edz, input bit accept);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (accept) sb.push_back('{elo, ehi, edz, cyc, edz ? 1 : W + 2});
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done();
        seen_done = 1'b0;
        for (int i = 0; i < 100 && !seen_done; i++) begin
            if (bus.done === 1'b1) seen_done = 1'b1;
            else @(negedge clk);
        end
        if (!seen_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lo"}, bus.lo, '0);
        check({tag, "_hi"}, bus.hi, '0);
        check({tag, "_busy"}, W'(bus.busy), '0);
        check({tag, "_done"}, W'(bus.done), '0);
        check({tag, "_div_zero"}, W'(bus.div_zero), '0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus.start = 1'b0;
        reset     = 1'b0;

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done();
        check("busy_in_done", W'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_after_done", W'(bus.busy), 32'd0);

        issue(32'hFFFF_FFF9, 32'd2, NEG_LO, NEG_HI, 1'b0, 1'b1);
        wait_done(); @(negedge clk);

        issue(32'd11, 32'd2, 32'd5, 32'd1, 1'b0, 1'b1);
        wait_done(); @(negedge clk);

        issue(32'd9, 32'd0, 32'd5, 32'd1, 1'b1, 1'b1);
        wait_done(); @(negedge clk);
        repeat (5) @(negedge clk);
        check("dz_hold_flag", W'(bus.div_zero), 32'd1);
        check("dz_hold_lo", bus.lo, 32'd5);
        check("dz_hold_hi", bus.hi, 32'd1);

        issue(32'h8000_0000, 32'hFFFF_FFFF, OVF_LO, OVF_HI, 1'b0, 1'b1);
        check("dz_cleared_on_start", W'(bus.div_zero), 32'd0);
        wait_done(); @(negedge clk);

        issue(32'd7, 32'hFFFF_FFFE, MIX_LO, MIX_HI, 1'b0, 1'b1);
        wait_done(); @(negedge clk);
        issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        wait_done(); @(negedge clk);
        issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b1);
        wait_done(); @(negedge clk);

        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b1);
        wait_done(); @(negedge clk);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_during_calc", W'(bus.busy), 32'd1);
        wait_done();
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        check("start_in_done_busy", W'(bus.busy), 32'd0);
        check("start_in_done_done", W'(bus.done), 32'd0);
        bus.dividend = 32'd20; bus.divisor = 32'd3;
        sb.push_back('{32'd6, 32'd2, 1'b0, cyc, W + 2});
        @(negedge clk);
        bus.start = 1'b0;
        check("accept_after_done_busy", W'(bus.busy), 32'd1);
        wait_done(); @(negedge clk);

        repeat (10) @(negedge clk);
        check("idle_hold_lo", bus.lo, 32'd6);
        check("idle_hold_hi", bus.hi, 32'd2);
        check("sb_empty", W'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
